reg_hazard_ctrl: RTL and testbench
==================================

// Module: reg_hazard_ctrl
// PURPOSE
//  Scoreboard/scheduler for the GPR file in the 5-stage core. Tracks in-flight register writes
//  (EX, MEM, WB) from the ID-stage read/write decode, picks a forwarding source per read port,
//  and raises a load-use stall that holds IF/ID and injects a bubble into EX. Sits beside ID.
// PARAMETERS
//  ADDR_W        5   GPR address width
//  LOAD_FWD_MEM  1   1: load data forwardable from MEM (1-cycle load-use stall); 0: from WB only (2 cycles)
//  CNT_W         16  width of the stall-cycle performance counter
// PORTS
//  clk             in   1       core clock
//  rst             in   1       synchronous reset, active high
//  id_valid        in   1       ID holds a real instruction
//  id_read_en_1    in   1       port-1 read enable from ID decode
//  id_read_en_2    in   1       port-2 read enable from ID decode
//  id_addr_1       in   ADDR_W  port-1 read address
//  id_addr_2       in   ADDR_W  port-2 read address
//  id_write_en     in   1       ID instruction writes a GPR
//  id_write_addr   in   ADDR_W  destination GPR
//  id_is_load      in   1       ID instruction is LB/LBU/LH/LHU/LW
//  stall_in        in   1       downstream (MEM/bus) stall; freezes all tracking
//  flush           in   1       exception/ERET flush; clears all tracked writes
//  stall_req       out  1       hold PC and IF/ID; bubble EX
//  fwd_sel_1       out  2       port-1 source: 0 regfile, 1 EX, 2 MEM, 3 WB
//  fwd_sel_2       out  2       port-2 source, same encoding
//  stall_cnt       out  CNT_W   saturating count of cycles with stall_req=1
// BEHAVIOUR
//  - State: three slots EX, MEM, WB, each {valid, addr, is_load}. Reset/flush: all valid=0, stall_cnt=0.
//  - Reset outputs: stall_req=0, fwd_sel_1=fwd_sel_2=0, stall_cnt=0.
//  - Match(slot,port) = id_valid & read_en & addr!=0 & slot.valid & slot.addr==addr.
//  - fwd_sel: youngest match wins, EX > MEM > WB; no match or addr 0 -> 0. Combinational, same cycle.
//  - stall_req (combinational) = id_valid & any port with Match(EX) & EX.is_load,
//    or, when LOAD_FWD_MEM=0, Match(MEM) & MEM.is_load. fwd_sel outputs are don't-care while stall_req=1.
//  - Slot update each rising edge, priority: rst > flush > stall_in > stall_req > normal.
//    flush: all slots invalid (flush overrides stall_in in the same cycle).
//    stall_in: all slots hold; stall_req still evaluated; stall_cnt does not increment.
//    stall_req: WB<=MEM, MEM<=EX, EX<=bubble (valid=0).
//    normal: WB<=MEM, MEM<=EX, EX<={id_valid & id_write_en & id_write_addr!=0, id_write_addr, id_is_load}.
//  - Writes to $0 are never tracked. Same destination in several slots is legal; youngest wins.
//  - Load-use latency: dependent instruction in ID stalls exactly 1 (LOAD_FWD_MEM=1) or
//    2 (LOAD_FWD_MEM=0) non-stall_in cycles, then issues with fwd_sel=2 or 3 respectively.
//  - stall_cnt += 1 when stall_req & ~stall_in & ~flush; saturates at all-ones, no wrap.
//  - WB slot models the regfile write port; regfile write-through is not assumed, so WB forwarding is required.
// STRUCTURE
//  - FWD_SEL_* encodings (REG/EX/MEM/WB) go as `define in the shared bus header beside REG_ADDR_BUS.
//  - One sub-module: fwd_select (per read port: three slot matches -> fwd_sel, load_hit); instantiate twice.
//  - Slot registers, update priority and stall counter live in the top module.
// TESTING
//  1 ADDIU $1 then ADDU $2,$1,$1 back-to-back -> no stall, fwd_sel_1=fwd_sel_2=1 on the ADDU's ID cycle.
//  2 LW $3 then ADDU $4,$3,$0 (LOAD_FWD_MEM=1) -> stall_req=1 one cycle, then fwd_sel_1=2, stall_cnt=1.
//  3 Same as 2 with LOAD_FWD_MEM=0 -> stall_req=1 two cycles, then fwd_sel_1=3, stall_cnt=2.
//  4 ORI $0 then read $0; LUI $5 then three NOPs then read $5 -> fwd_sel=0 in both cases.
//  5 ADDIU $6; ORI $6; read $6 -> fwd_sel=1 (EX beats MEM); assert stall_in 3 cycles mid-sequence -> selects unchanged.
//  6 LW $7 in EX, flush and stall_in together, then read $7 -> no stall, fwd_sel=0; rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared types for the GPR hazard controller: forwarding source encoding.
package reg_hazard_ctrl_pkg;

  // Operand source for an ID read port. REG means the register file value is current.
  typedef enum logic [1:0] {
    FWD_SEL_REG = 2'd0,
    FWD_SEL_EX  = 2'd1,
    FWD_SEL_MEM = 2'd2,
    FWD_SEL_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/reg_hazard_ctrl_fwd_select.sv
// Per-read-port hazard decode: compares one ID read address against the three
// in-flight write slots, picks the youngest matching producer and flags a
// load result that is not yet forwardable.
module fwd_select
  import reg_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned LOAD_FWD_MEM = 1
) (
  input  logic              id_valid,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic              ex_is_load,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_is_load,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [1:0]        fwd_sel,
  output logic              load_hit
);

  logic rd_act;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  // $0 is hardwired to zero, so a read of it never depends on anything in flight.
  assign rd_act  = id_valid & read_en & (addr != '0);
  assign hit_ex  = rd_act & ex_valid  & (ex_addr  == addr);
  assign hit_mem = rd_act & mem_valid & (mem_addr == addr);
  assign hit_wb  = rd_act & wb_valid  & (wb_addr  == addr);

  // Youngest producer wins: EX holds the most recent write, WB the oldest.
  always_comb begin
    fwd_sel = FWD_SEL_REG;
    if (hit_ex)       fwd_sel = FWD_SEL_EX;
    else if (hit_mem) fwd_sel = FWD_SEL_MEM;
    else if (hit_wb)  fwd_sel = FWD_SEL_WB;
  end

  // A load in EX never has data yet; a load in MEM has data only when the
  // memory stage result is wired into the forwarding mux.
  assign load_hit = (hit_ex & ex_is_load) |
                    ((LOAD_FWD_MEM == 0) & hit_mem & mem_is_load);

endmodule

// File: rtl/reg_hazard_ctrl.sv
// GPR scoreboard beside the ID stage. Tracks the writes sitting in EX, MEM and
// WB, selects a forwarding source for each read port and requests a load-use
// stall.
//
// ID handshake: id_valid qualifies the instruction in ID. While stall_req=1
// that instruction is not accepted (PC and IF/ID hold, EX receives a bubble)
// and the same instruction must be presented again on the next cycle;
// it is accepted on a cycle with id_valid=1, stall_req=0 and stall_in=0.
module reg_hazard_ctrl
  import reg_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned LOAD_FWD_MEM = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_read_en_1,
  input  logic              id_read_en_2,
  input  logic [ADDR_W-1:0] id_addr_1,
  input  logic [ADDR_W-1:0] id_addr_2,
  input  logic              id_write_en,
  input  logic [ADDR_W-1:0] id_write_addr,
  input  logic              id_is_load,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stall_req,
  output logic [1:0]        fwd_sel_1,
  output logic [1:0]        fwd_sel_2,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ex_valid,  mem_valid,  wb_valid;
  logic [ADDR_W-1:0] ex_addr,   mem_addr,   wb_addr;
  logic              ex_is_load, mem_is_load, wb_is_load;
  logic              load_hit_1, load_hit_2;
  logic              id_tracked;

  fwd_select #(.ADDR_W(ADDR_W), .LOAD_FWD_MEM(LOAD_FWD_MEM)) u_fwd_1 (
    .id_valid    (id_valid),
    .read_en     (id_read_en_1),
    .addr        (id_addr_1),
    .ex_valid    (ex_valid),
    .ex_addr     (ex_addr),
    .ex_is_load  (ex_is_load),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_is_load (mem_is_load),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .fwd_sel     (fwd_sel_1),
    .load_hit    (load_hit_1)
  );

  fwd_select #(.ADDR_W(ADDR_W), .LOAD_FWD_MEM(LOAD_FWD_MEM)) u_fwd_2 (
    .id_valid    (id_valid),
    .read_en     (id_read_en_2),
    .addr        (id_addr_2),
    .ex_valid    (ex_valid),
    .ex_addr     (ex_addr),
    .ex_is_load  (ex_is_load),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_is_load (mem_is_load),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .fwd_sel     (fwd_sel_2),
    .load_hit    (load_hit_2)
  );

  assign stall_req  = load_hit_1 | load_hit_2;
  // Writes to $0 are discarded by the regfile, so they are never tracked.
  assign id_tracked = id_valid & id_write_en & (id_write_addr != '0);

  // Slot pipeline: rst > flush > stall_in (hold) > stall_req (bubble) > issue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid    <= 1'b0;
      ex_addr     <= '0;
      ex_is_load  <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_is_load <= 1'b0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_is_load  <= 1'b0;
    end else if (!stall_in) begin
      wb_valid    <= mem_valid;
      wb_addr     <= mem_addr;
      wb_is_load  <= mem_is_load;
      mem_valid   <= ex_valid;
      mem_addr    <= ex_addr;
      mem_is_load <= ex_is_load;
      if (stall_req) begin
        ex_valid    <= 1'b0;
        ex_addr     <= '0;
        ex_is_load  <= 1'b0;
      end else begin
        ex_valid    <= id_tracked;
        ex_addr     <= id_write_addr;
        ex_is_load  <= id_is_load;
      end
    end
  end

  // Stall-cycle counter: cleared with the slots on reset or flush, counts only
  // cycles where the stall actually inserts a bubble, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stall_cnt <= '0;
    end else if (stall_req && !stall_in && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Bench for reg_hazard_ctrl: two instances on shared stimulus, one with MEM
// load forwarding (16-bit counter) and one without (3-bit counter, so
// saturation is reachable). A reference model of the in-flight writes feeds an
// expected queue; a monitor pops and compares every cycle.
module tb_reg_hazard_ctrl;

  localparam int EXP_W = 42;  // per instance {stall, fwd1, fwd2, cnt[15:0]}

  logic       clk = 1'b0;
  logic       rst, id_valid, id_read_en_1, id_read_en_2, id_write_en, id_is_load;
  logic       stall_in, flush;
  logic [4:0] id_addr_1, id_addr_2, id_write_addr;

  logic       stall_req_0, stall_req_1;
  logic [1:0] fwd_sel_1_0, fwd_sel_2_0, fwd_sel_1_1, fwd_sel_2_1;
  logic [2:0] stall_cnt_0;
  logic [15:0] stall_cnt_1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reg_hazard_ctrl #(.ADDR_W(5), .LOAD_FWD_MEM(0), .CNT_W(3)) u_dut_0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
    .id_addr_1(id_addr_1), .id_addr_2(id_addr_2),
    .id_write_en(id_write_en), .id_write_addr(id_write_addr), .id_is_load(id_is_load),
    .stall_in(stall_in), .flush(flush),
    .stall_req(stall_req_0), .fwd_sel_1(fwd_sel_1_0), .fwd_sel_2(fwd_sel_2_0),
    .stall_cnt(stall_cnt_0)
  );

  reg_hazard_ctrl #(.ADDR_W(5), .LOAD_FWD_MEM(1), .CNT_W(16)) u_dut_1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
    .id_addr_1(id_addr_1), .id_addr_2(id_addr_2),
    .id_write_en(id_write_en), .id_write_addr(id_write_addr), .id_is_load(id_is_load),
    .stall_in(stall_in), .flush(flush),
    .stall_req(stall_req_1), .fwd_sel_1(fwd_sel_1_1), .fwd_sel_2(fwd_sel_2_1),
    .stall_cnt(stall_cnt_1)
  );

  // ---------------- reference model ----------------
  // Per instance: list of in-flight writes, index 0 = most recent (age 1).
  logic       m_v[2][3];
  logic [4:0] m_a[2][3];
  logic       m_l[2][3];
  int         m_cnt[2];
  int         cnt_max[2] = '{7, 65535};
  logic       m_stall[2];

  // Age (1..3) of the most recent in-flight write to the register, 0 if none.
  function automatic int youngest(int d, logic v, logic en, logic [4:0] a);
    if (!v || !en || a == 5'd0) return 0;
    for (int s = 0; s < 3; s++)
      if (m_v[d][s] && m_a[d][s] == a) return s + 1;
    return 0;
  endfunction

  // A load whose data is still too young: age 1 always, age 2 when MEM
  // forwarding is absent (instance 0).
  function automatic logic load_blocked(int d, logic v, logic en, logic [4:0] a);
    int max_age;
    if (!v || !en || a == 5'd0) return 1'b0;
    max_age = (d == 0) ? 2 : 1;
    for (int s = 0; s < max_age; s++)
      if (m_v[d][s] && m_l[d][s] && m_a[d][s] == a) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic r1, input logic [4:0] a1,
                      input logic r2, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic ld,
                      input logic si, input logic fl, input logic rs);
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #1;
    id_valid = v; id_read_en_1 = r1; id_addr_1 = a1; id_read_en_2 = r2; id_addr_2 = a2;
    id_write_en = we; id_write_addr = wa; id_is_load = ld;
    stall_in = si; flush = fl; rst = rs;
    e = '0;
    for (int d = 0; d < 2; d++) begin
      logic [1:0] f1, f2;
      logic [15:0] c;
      m_stall[d] = load_blocked(d, v, r1, a1) | load_blocked(d, v, r2, a2);
      f1 = 2'(youngest(d, v, r1, a1));
      f2 = 2'(youngest(d, v, r2, a2));
      c  = 16'(m_cnt[d]);
      e[d*21 +: 21] = {m_stall[d], f1, f2, c};
    end
    exp_q.push_back(e);
    // advance the model to the next cycle
    for (int d = 0; d < 2; d++) begin
      if (rs || fl) begin
        for (int s = 0; s < 3; s++) m_v[d][s] = 1'b0;
        m_cnt[d] = 0;
      end else if (!si) begin
        for (int s = 2; s > 0; s--) begin
          m_v[d][s] = m_v[d][s-1]; m_a[d][s] = m_a[d][s-1]; m_l[d][s] = m_l[d][s-1];
        end
        if (m_stall[d]) begin
          m_v[d][0] = 1'b0;
          if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
        end else begin
          m_v[d][0] = v & we & (wa != 5'd0); m_a[d][0] = wa; m_l[d][0] = ld;
        end
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  // Present a dependent instruction until neither instance stalls (bounded).
  task automatic use_hold(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa);
    int tries = 0;
    do begin
      step(1, 1, a1, 1, a2, 1, wa, 0, 0, 0, 0);
      tries++;
    end while ((m_stall[0] || m_stall[1]) && tries < 4);
    if (m_stall[0] || m_stall[1]) begin
      n_checks++; n_fail++;
      $display("FAIL use_hold: stall still expected after %0d cycles, required release within 3", tries);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string name, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0d, required %0d", name, d, $time, act, exp);
    end
  endtask

  initial begin
    logic [EXP_W-1:0] e;
    logic [20:0] x;
    int a_st[2], a_f1[2], a_f2[2], a_c[2];
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_st[0] = stall_req_0; a_f1[0] = fwd_sel_1_0; a_f2[0] = fwd_sel_2_0; a_c[0] = stall_cnt_0;
        a_st[1] = stall_req_1; a_f1[1] = fwd_sel_1_1; a_f2[1] = fwd_sel_2_1; a_c[1] = stall_cnt_1;
        for (int d = 0; d < 2; d++) begin
          x = e[d*21 +: 21];
          chk("stall_req", d, a_st[d], x[20]);
          chk("stall_cnt", d, a_c[d], x[15:0]);
          if (!x[20]) begin
            chk("fwd_sel_1", d, a_f1[d], x[19:18]);
            chk("fwd_sel_2", d, a_f2[d], x[17:16]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cyc;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_stall[d] = 1'b0;
      for (int s = 0; s < 3; s++) begin m_v[d][s] = 1'b0; m_a[d][s] = '0; m_l[d][s] = 1'b0; end
    end
    rst = 1; id_valid = 0; id_read_en_1 = 0; id_read_en_2 = 0; id_addr_1 = 0; id_addr_2 = 0;
    id_write_en = 0; id_write_addr = 0; id_is_load = 0; stall_in = 0; flush = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset state visible

    // ALU back-to-back: ADDIU $1 ; ADDU $2,$1,$1 -> both ports from EX
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    nop(3);

    // LW $3 ; ADDU $4,$3,$0 -> 1 stall (MEM fwd) / 2 stalls (WB fwd)
    step(1, 1, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    use_hold(3, 0, 4);
    nop(3);

    // ORI $0 then read $0 ; LUI $5, three NOPs, read $5 -> regfile
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 9, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    nop(3);
    step(1, 1, 5, 1, 5, 1, 10, 0, 0, 0, 0);
    nop(3);

    // ADDIU $6 ; ORI $6 ; read $6 with stall_in held 3 cycles
    step(1, 1, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    step(1, 1, 6, 0, 0, 1, 6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 6, 1, 6, 1, 11, 0, 1, 0, 0);
    step(1, 1, 6, 1, 6, 1, 11, 0, 0, 0, 0);
    nop(3);

    // LW $7 ; flush with stall_in ; read $7 -> nothing tracked
    step(1, 1, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    step(1, 1, 7, 0, 0, 1, 12, 0, 1, 1, 0);
    step(1, 1, 7, 1, 7, 1, 12, 0, 0, 0, 0);
    nop(2);
    // LW $8 ; dependent read with rst mid-stall -> all clear next cycle
    step(1, 1, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    step(1, 1, 8, 1, 8, 1, 13, 0, 0, 0, 1);
    step(1, 1, 8, 1, 8, 1, 13, 0, 0, 0, 0);

    // repeated load-use to drive the 3-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 0, 1, 9, 1, 0, 0, 0);
      use_hold(0, 9, 14);
    end
    nop(3);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 85,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) < 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
